// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM states and width constants.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned CNT_W     = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider32_if.sv
// Valid/ready operand and result channel between the execute stage and the divider.
interface seq_divider32_if #(
    parameter int unsigned WIDTH = div_pkg::DIV_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             signed_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, signed_op, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, signed_op, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/prefix_sub.sv
// Combinational a - b as a + ~b + 1 on a parallel-prefix carry tree; diff MSB doubles as the sign.
module prefix_sub #(
    parameter int unsigned WIDTH = 33
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] gn;
    logic [WIDTH-1:0] pn;

    always_comb begin
        p  = a ^ ~b;
        g  = a & ~b;
        pp = p;
        gn = '0;
        pn = '0;
        // Carry-in of 1 is folded into bit 0's group generate.
        g[0] = g[0] | p[0];
        for (int unsigned d = 1; d < WIDTH; d = d * 2) begin
            gn = g;
            pn = pp;
            for (int unsigned i = d; i < WIDTH; i++) begin
                gn[i] = g[i] | (pp[i] & g[i-d]);
                pn[i] = pp[i] & pp[i-d];
            end
            g  = gn;
            pp = pn;
        end
        diff = p ^ {g[WIDTH-2:0], 1'b1};
    end

endmodule

// File: rtl/seq_divider32.sv
// Restoring divider, one quotient bit per clock, behind a valid/ready handshake.
// Define SIGNED_DIV_EN to honour signed_op (two's-complement operands).
module seq_divider32
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input logic            clk,
    input logic            rst,
    seq_divider32_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo_o;
    logic [WIDTH-1:0] rem_o;
    logic             dbz_o;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             ovf;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

    prefix_sub #(.WIDTH(WIDTH + 1)) u_sub (
        .a    (shifted),
        .b    ({1'b0, dvsr}),
        .diff (diff)
    );

    assign r_next = diff[WIDTH] ? shifted : diff;
    assign q_next = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

`ifdef SIGNED_DIV_EN
    logic sign_a;
    logic sign_b;
    logic neg_q;
    logic neg_r;

    assign sign_a = bus.signed_op & bus.dividend[WIDTH-1];
    assign sign_b = bus.signed_op & bus.divisor[WIDTH-1];
    assign a_mag  = sign_a ? -bus.dividend : bus.dividend;
    assign b_mag  = sign_b ? -bus.divisor  : bus.divisor;
    assign ovf    = bus.signed_op && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                    && (bus.divisor == '1);
    assign q_fix  = neg_q ? -q_next : q_next;
    assign r_fix  = neg_r ? -r_next[WIDTH-1:0] : r_next[WIDTH-1:0];
`else
    logic unused_signed_op;

    assign unused_signed_op = bus.signed_op;
    assign a_mag = bus.dividend;
    assign b_mag = bus.divisor;
    assign ovf   = 1'b0;
    assign q_fix = q_next;
    assign r_fix = r_next[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem_q <= '0;
            quo_q <= '0;
            dvsr  <= '0;
            count <= '0;
            quo_o <= '0;
            rem_o <= '0;
            dbz_o <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        rem_q <= '0;
                        quo_q <= a_mag;
                        dvsr  <= b_mag;
                        count <= CW'(WIDTH);
`ifdef SIGNED_DIV_EN
                        neg_q <= sign_a ^ sign_b;
                        neg_r <= sign_a;
`endif
                        if (bus.divisor == '0) begin
                            quo_o <= '1;
                            rem_o <= bus.dividend;
                            dbz_o <= 1'b1;
                            state <= DONE;
                        end else if (ovf) begin
                            quo_o <= bus.dividend;
                            rem_o <= '0;
                            dbz_o <= 1'b0;
                            state <= DONE;
                        end else begin
                            dbz_o <= 1'b0;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem_q <= r_next;
                    quo_q <= q_next;
                    count <= count - 1'b1;
                    // Last step publishes the fixed-up result directly so latency stays WIDTH+1.
                    if (count == CW'(1)) begin
                        quo_o <= q_fix;
                        rem_o <= r_fix;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.quotient    = quo_o;
    assign bus.remainder   = rem_o;
    assign bus.div_by_zero = dbz_o;

endmodule

// File: tb/tb_seq_divider32.sv
// Randomized and directed checks of seq_divider32 against a plain-arithmetic reference.
module tb_seq_divider32;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    seq_divider32_if #(.WIDTH(W)) bus ();

    seq_divider32 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Division rules stated directly: divide-by-zero, signed overflow, then ordinary quotient/remainder.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dbz, output logic fast);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic use_signed;
        sa = a;
        sb = b;
`ifdef SIGNED_DIV_EN
        use_signed = sgn;
`else
        use_signed = 1'b0 & sgn;
`endif
        dbz  = 1'b0;
        fast = 1'b0;
        if (b == 0) begin
            q = '1; r = a; dbz = 1'b1; fast = 1'b1;
        end else if (use_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = '0; fast = 1'b1;
        end else if (use_signed) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input int unsigned hold);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic edbz;
        logic efast;
        int unsigned lat;
        int unsigned waited;
        ref_div(a, b, sgn, eq, er, edbz, efast);
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(posedge clk); #1; waited++;
        end
        check("in_ready_idle", bus.in_ready, 1);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.signed_op = sgn;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            if (lat == 10) begin
                check("in_ready_busy", bus.in_ready, 0);
                bus.in_valid = 1'b1;
                bus.dividend = $urandom;
                bus.divisor  = 32'd1;
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            lat++;
        end
        check("latency", lat, efast ? 1 : 33);
        check("quotient", bus.quotient, eq);
        check("remainder", bus.remainder, er);
        check("div_by_zero", bus.div_by_zero, edbz);
        check("in_ready_done", bus.in_ready, 0);
        for (int unsigned i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", bus.out_valid, 1);
            check("hold_ready", bus.in_ready, 0);
            check("hold_quotient", bus.quotient, eq);
            check("hold_remainder", bus.remainder, er);
            check("hold_dbz", bus.div_by_zero, edbz);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("ret_valid", bus.out_valid, 0);
        check("ret_ready", bus.in_ready, 1);
    endtask

    task automatic reset_mid_op();
        int unsigned seen;
        bus.dividend  = 32'd1000;
        bus.divisor   = 32'd3;
        bus.signed_op = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (16) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_valid", bus.out_valid, 0);
        check("rst_ready", bus.in_ready, 1);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("rst_no_result", seen, 0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.signed_op = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_quotient", bus.quotient, 0);
        check("reset_remainder", bus.remainder, 0);
        check("reset_dbz", bus.div_by_zero, 0);

        do_op(32'd100, 32'd7, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        do_op(32'd5, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(32'd1234, 32'd0, 1'b0, 0);
        do_op(32'd100, 32'd7, 1'b0, 10);
        reset_mid_op();
        do_op(32'd9, 32'd3, 1'b0, 0);

        // Signed cases; without the feature the same stimulus must give unsigned results.
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        do_op(32'hFFFF_FFF9, 32'd0, 1'b1, 0);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b0, 0);

        for (int unsigned n = 0; n < 40; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1, 2, 3: rb = $urandom_range(1, 255);
                4: rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            do_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
